// File: rtl/instr_feeder.sv
// Program buffer and encoder for the multi-cycle 8-bit register-file processor.
// Latency: a load takes one cycle per word; in RUN, instruction follows counter one cycle later (registered).
// Backpressure: op_ready drops once the buffer is full or the block is in RUN; refused offers set sticky overflow in LOAD.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   op_valid/op_ready load-port handshake
//   op_kind           0=ADD 1=SUB 2=ADDIU 3=NOP
//   op_rs/op_rt/op_rd register fields, op_imm ADDIU immediate
//   load_done         leaves LOAD for RUN
//   counter           processor fetch counter
//   instruction       registered 32-bit word to the processor
//   prog_len          words loaded (0..DEPTH)
//   running           high in RUN
//   overflow          sticky: offer refused because buffer was full during LOAD
module instr_feeder #(
  parameter int DEPTH = 16,
  parameter int PC_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [1:0]      op_kind,
  input  logic [4:0]      op_rs,
  input  logic [4:0]      op_rt,
  input  logic [4:0]      op_rd,
  input  logic [15:0]     op_imm,
  input  logic            load_done,
  input  logic [PC_W-1:0] counter,
  output logic [31:0]     instruction,
  output logic [PC_W:0]   prog_len,
  output logic            running,
  output logic            overflow
);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [PC_W:0] FULL_LEN = (PC_W+1)'(DEPTH);

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic [31:0] enc_word;
  logic [31:0] prog_buf [DEPTH];

  // Next state and handshake outputs, all derived from the current state.
  always_comb begin
    state_nxt = state;
    op_ready  = 1'b0;
    running   = 1'b0;
    accept    = 1'b0;
    case (state)
      S_LOAD: begin
        op_ready = (prog_len < FULL_LEN);
        accept   = op_valid && op_ready;
        // A handshake in the same cycle is still stored before leaving LOAD.
        if (load_done) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        running = 1'b1;
      end
      default: begin
        state_nxt = S_LOAD;
      end
    endcase
  end

  // MIPS-format encoding; fields go through untouched, register 0 included.
  always_comb begin
    enc_word = 32'h0;
    case (op_kind)
      2'd0:    enc_word = {6'd0, op_rs, op_rt, op_rd, 5'd0, 6'd33};
      2'd1:    enc_word = {6'd0, op_rs, op_rt, op_rd, 5'd0, 6'd35};
      2'd2:    enc_word = {6'd9, op_rs, op_rt, op_imm};
      default: enc_word = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_LOAD;
      prog_len    <= '0;
      overflow    <= 1'b0;
      instruction <= 32'h0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        prog_len <= prog_len + 1'b1;
      end
      if (state == S_LOAD && op_valid && !op_ready) begin
        overflow <= 1'b1;
      end
      // Held at zero during LOAD so early fetches decode as NOPs; entries past
      // prog_len may hold stale data from before a reset, so they read as 0.
      if (state == S_RUN && ({1'b0, counter} < prog_len)) begin
        instruction <= prog_buf[counter];
      end else begin
        instruction <= 32'h0;
      end
    end
  end

  // Buffer storage is not reset; prog_len alone decides what is reachable.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      prog_buf[prog_len[PC_W-1:0]] <= enc_word;
    end
  end

endmodule

// File: tb/tb_instr_feeder.sv
module tb_instr_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op_kind;
  logic [4:0]  op_rs;
  logic [4:0]  op_rt;
  logic [4:0]  op_rd;
  logic [15:0] op_imm;
  logic        load_done;
  logic [3:0]  counter;
  logic [31:0] instruction;
  logic [4:0]  prog_len;
  logic        running;
  logic        overflow;

  instr_feeder #(.DEPTH(16), .PC_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_kind     (op_kind),
    .op_rs       (op_rs),
    .op_rt       (op_rt),
    .op_rd       (op_rd),
    .op_imm      (op_imm),
    .load_done   (load_done),
    .counter     (counter),
    .instruction (instruction),
    .prog_len    (prog_len),
    .running     (running),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] mbuf [16];
  int          mlen;
  bit          movf;
  bit          mrun;
  logic [31:0] exp_q [$];

  function automatic logic [31:0] ref_enc(input logic [1:0] k, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [15:0] imm);
    logic [31:0] w;
    w = 32'h0;
    if (k == 2'd0)      w = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'd33;
    else if (k == 2'd1) w = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'd35;
    else if (k == 2'd2) w = (32'd9 << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ".prog_len"}, 32'(prog_len), 32'(mlen));
    chk({tag, ".overflow"}, 32'(overflow), 32'(movf));
    chk({tag, ".running"},  32'(running),  32'(mrun));
    chk({tag, ".op_ready"}, 32'(op_ready), 32'(!mrun && mlen < 16));
  endtask

  task automatic do_reset();
    rst = 1'b1; op_valid = 1'b0; load_done = 1'b0;
    step();
    rst = 1'b0;
    mlen = 0; movf = 1'b0; mrun = 1'b0;
    chk("rst.instruction", instruction, 32'h0);
    chk_status("rst");
  endtask

  // Offers one operation (or none when v=0) for one cycle, updating the model.
  task automatic offer(input string tag, input bit v, input logic [1:0] k, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                       input bit done);
    op_valid = v; op_kind = k; op_rs = rs; op_rt = rt; op_rd = rd; op_imm = imm;
    load_done = done;
    if (!mrun) begin
      if (v && mlen < 16) begin
        mbuf[mlen] = ref_enc(k, rs, rt, rd, imm);
        mlen++;
      end else if (v) begin
        movf = 1'b1;
      end
      if (done) mrun = 1'b1;
    end
    step();
    op_valid = 1'b0; load_done = 1'b0;
    chk_status(tag);
  endtask

  task automatic fetch(input string tag, input logic [3:0] c);
    counter = c;
    exp_q.push_back((mrun && int'(c) < mlen) ? mbuf[c] : 32'h0);
    step();
    chk(tag, instruction, exp_q.pop_front());
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_kind = 2'd3; op_rs = '0; op_rt = '0; op_rd = '0;
    op_imm = '0; load_done = 1'b0; counter = '0;
    mlen = 0; movf = 1'b0; mrun = 1'b0;

    // Reset state, then ADD and SUB-with-load_done in the same cycle
    do_reset();
    offer("ld_add", 1'b1, 2'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
    chk("ld_add.word", ref_enc(2'd0, 5'd1, 5'd2, 5'd3, 16'h0), 32'h00221821);
    chk("load.instr_zero", instruction, 32'h0);
    offer("ld_sub_done", 1'b1, 2'd1, 5'd3, 5'd1, 5'd4, 16'h0, 1'b1);
    fetch("runA.c0", 4'd0);
    fetch("runA.c1", 4'd1);
    fetch("runA.c2", 4'd2);
    // op_valid in RUN is ignored and does not set overflow
    offer("run_ignore", 1'b1, 2'd0, 5'd7, 5'd7, 5'd7, 16'h0, 1'b0);
    fetch("runA.c1b", 4'd1);

    // Reset mid-RUN
    counter = 4'd0;
    do_reset();
    fetch("rstrun.instr", 4'd1);

    // SUB, ADDIU, then load_done alone
    offer("ld_sub", 1'b1, 2'd1, 5'd3, 5'd1, 5'd4, 16'h0, 1'b0);
    offer("ld_addiu", 1'b1, 2'd2, 5'd0, 5'd1, 5'd0, 16'd5, 1'b0);
    offer("ld_done", 1'b0, 2'd3, 5'd0, 5'd0, 5'd0, 16'h0, 1'b1);
    counter = 4'd0;
    exp_q.push_back(32'h00612023);
    step();
    chk("runB.c0", instruction, exp_q.pop_front());
    counter = 4'd1;
    exp_q.push_back(32'h24010005);
    step();
    chk("runB.c1", instruction, exp_q.pop_front());
    counter = 4'd2;
    exp_q.push_back(32'h0);
    step();
    chk("runB.c2", instruction, exp_q.pop_front());

    // Fill: 17 consecutive offers, 16 accepted, 17th overflows
    do_reset();
    for (int i = 0; i < 17; i++) begin
      offer($sformatf("fill%0d", i), 1'b1, 2'(i % 4), 5'(i), 5'(i + 1), 5'(31 - i),
            16'(16'h100 + i), 1'b0);
    end
    offer("fill_idle", 1'b0, 2'd3, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0);
    offer("fill_done", 1'b0, 2'd3, 5'd0, 5'd0, 5'd0, 16'h0, 1'b1);
    for (int c = 0; c < 16; c++) begin
      fetch($sformatf("runC.c%0d", c), 4'(c));
    end
    fetch("runC.wrap", 4'd0);

    // load_done with an empty buffer serves only NOPs
    do_reset();
    offer("empty_done", 1'b0, 2'd3, 5'd0, 5'd0, 5'd0, 16'h0, 1'b1);
    fetch("runD.c0", 4'd0);
    fetch("runD.c5", 4'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_feeder.md
# instr_feeder

Instruction-side companion to the multi-cycle 8-bit register-file processor. It accepts assembled operations (ADD, SUB, ADDIU, NOP) through a valid/ready load port and encodes each one into a 32-bit MIPS-format word. The words go into an internal program buffer. In the run phase the block returns the word indexed by the processor's `counter` output on `instruction`, so the processor always fetches the entry it is about to execute.

## Interface
- `DEPTH`, 16: program buffer entries; must equal 2^`PC_W`
- `PC_W`, 4: width of the processor `counter`
- `clk`  in  1  rising-edge clock, shared with the processor
- `rst`  in  1  synchronous, active-high reset
- `op_valid`  in  1  operation offered on the load port
- `op_ready`  out  1  block accepts the offered operation this cycle
- `op_kind`  in  2  0=ADD, 1=SUB, 2=ADDIU, 3=NOP
- `op_rs`, `op_rt`, `op_rd`  in  5 each  register fields
- `op_imm`  in  16  immediate (ADDIU only)
- `load_done`  in  1  ends the load phase
- `counter`  in  `PC_W`  processor fetch counter
- `instruction`  out  32  word to the processor
- `prog_len`  out  `PC_W`+1  number of words loaded (0..`DEPTH`)
- `running`  out  1  high in the RUN state
- `overflow`  out  1  sticky; set when `op_valid` is high while the buffer is full in LOAD

## Operation
- One clock; reset is synchronous and active-high.
- States:
  - LOAD (reset state) -> RUN on `load_done`.
  - RUN -> LOAD only on `rst`.
- Encoding (`rs`=[25:21], `rt`=[20:16], `rd`=[15:11], `shamt`=0):
  - ADD: opcode 0, func 33.
  - SUB: opcode 0, func 35.
  - ADDIU: opcode 9, [15:0]=`op_imm`.
  - NOP: 32'h0. The processor treats this as an invalid func, so nothing is written back.
  - Field values are encoded verbatim. No rd/rt=0 filtering; the processor handles register 0.
- LOAD phase:
  - `op_ready` = (`prog_len` < `DEPTH`), combinational from state.
  - Handshake when `op_valid` && `op_ready`: encoded word -> buf[`prog_len`], then `prog_len` += 1.
  - `op_valid` && !`op_ready`: operation dropped, `overflow` <= 1.
  - `load_done` together with an accepted handshake: the word is stored first, then the state is RUN next cycle.
  - `load_done` with `prog_len`=0 is legal. RUN then serves only NOPs.
  - `instruction` is held at 0 throughout LOAD, so processor fetches during load are harmless NOPs.
- RUN phase:
  - `op_ready`=0. `op_valid` is ignored and does not set `overflow`.
  - Each cycle: `instruction` <= (`counter` < `prog_len`) ? buf[`counter`] : 0.
  - `counter` wrap-around (15 -> 0) re-serves buf[0]. No special handling.
- Reset:
  - Clears to LOAD, `prog_len`=0, `overflow`=0, `instruction`=0.
  - Buffer contents are not cleared; they are unreachable because `prog_len`=0.
  - `rst` mid-LOAD or mid-RUN overrides every other input that cycle.

## Timing
- Reset values: `op_ready`=1, `running`=0, `instruction`=0, `prog_len`=0, `overflow`=0.
- Load throughput: one word per cycle. `prog_len` updates on the edge after the handshake.
- `running` rises on the edge after `load_done` is sampled.
- Fetch latency: one cycle from a `counter` change to `instruction` valid.
  - The processor increments `counter` on capture and samples `instruction` again 5 cycles later, so the margin is 4 cycles.
- `instruction` is a register output, with no combinational path from `counter`.
- The first RUN-phase `instruction` update happens on the cycle after `running` rises.

## Test plan
- Reset, then load ADD rs=1 rt=2 rd=3 -> buf[0]=32'h00221821, `prog_len`=1.
- Load SUB rs=3 rt=1 rd=4, then ADDIU rs=0 rt=1 imm=5, then `load_done`; drive `counter`=0,1,2 -> `instruction`=32'h00612023, 32'h24010005, then 32'h0 (beyond `prog_len`=2), each one cycle after `counter` changes.
- Hold `op_valid` for 17 cycles with NOPs -> 16 accepts, `op_ready`=0 at `prog_len`=16, `overflow`=1 on cycle 17 and stays 1.
- `op_valid` and `load_done` in the same cycle with ADD -> word stored, `prog_len` incremented, `running`=1 next cycle.
- Assert `rst` mid-RUN -> next cycle `running`=0, `instruction`=0, `prog_len`=0, `op_ready`=1, `overflow`=0.
- Integration: load ADDIU $1,$0,5; ADDIU $2,$0,3; SUB $3,$1,$2 padded with NOPs; run the processor with MAX_PC=10 and OUTPUT_REG=3 -> `finalResult`=2.
